lcd_read_req_gen: RTL and testbench



---
 rtl/frame_buf_pkg.sv | 12 +
 rtl/lcd_read_req_gen_if.sv | 13 +
 rtl/sync_edge_det.sv | 32 +++
 rtl/lcd_read_req_gen.sv | 138 +++++++++++++
 tb/tb_lcd_read_req_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer definitions for the LCD read-request path.
package frame_buf_pkg;

   localparam int unsigned INDEX_W  = 2;
   localparam int unsigned BANK_CNT = 3;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } req_state_t;

endpackage

// File: rtl/lcd_read_req_gen_if.sv
// Frame read request channel between the LCD request generator and the SDRAM read side.
interface lcd_read_req_gen_if #(
   parameter int unsigned INDEX_W = frame_buf_pkg::INDEX_W
);

   logic               read_req;
   logic               read_req_ack;
   logic [INDEX_W-1:0] read_addr_index;

   modport master (output read_req, output read_addr_index, input read_req_ack);
   modport slave  (input read_req, input read_addr_index, output read_req_ack);

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a delay flop; emits rise/fall/toggle pulses of the synced level.
module sync_edge_det #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise_c,
   output logic fall_c,
   output logic toggle_c
);

   logic [DEPTH-1:0] sync_q;
   logic             dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[DEPTH-2:0], d};
         dly_q  <= sync_q[DEPTH-1];
      end
   end

   assign level    = sync_q[DEPTH-1];
   assign rise_c   = sync_q[DEPTH-1] & ~dly_q;
   assign fall_c   = ~sync_q[DEPTH-1] & dly_q;
   assign toggle_c = sync_q[DEPTH-1] ^ dly_q;

endmodule

// File: rtl/lcd_read_req_gen.sv
// Issues one frame-buffer read request per LCD frame start, pointing at the newest completed write bank.
// Optional stale-bank re-read statistics: define LCD_READ_REPEAT_STAT_EN.
module lcd_read_req_gen #(
   parameter int unsigned INDEX_W        = frame_buf_pkg::INDEX_W,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned ACK_TIMEOUT    = 4096,
   parameter int unsigned VS_ACTIVE_HIGH = 1
) (
   input  logic                  rst,
   input  logic                  pclk,
   input  logic                  lcd_vsync,
   input  logic                  wr_done_toggle,
   input  logic [INDEX_W-1:0]    wr_done_index,
   lcd_read_req_gen_if.master    rd,
   output logic                  frame_valid,
   output logic                  timeout_err,
   output logic [7:0]            overrun_cnt,
   output logic [15:0]           repeat_cnt
);

   import frame_buf_pkg::*;

   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   logic               vs_rise_c, vs_fall_c, unused_vs_level, unused_vs_tog;
   logic               done_evt_c, unused_done_level, unused_done_rise, unused_done_fall;
   logic               frame_start_c;
   logic [INDEX_W-1:0] idx_s0_q, idx_s1_q, last_idx_q, addr_q;
   logic               req_q;
   logic [CNT_W-1:0]   cnt_q;
   req_state_t         state_q;

   sync_edge_det #(.DEPTH(SYNC_STAGES)) u_vs_sync (
      .clk      (pclk),
      .rst      (rst),
      .d        (lcd_vsync),
      .level    (unused_vs_level),
      .rise_c   (vs_rise_c),
      .fall_c   (vs_fall_c),
      .toggle_c (unused_vs_tog)
   );

   sync_edge_det #(.DEPTH(SYNC_STAGES)) u_done_sync (
      .clk      (pclk),
      .rst      (rst),
      .d        (wr_done_toggle),
      .level    (unused_done_level),
      .rise_c   (unused_done_rise),
      .fall_c   (unused_done_fall),
      .toggle_c (done_evt_c)
   );

   assign frame_start_c = (VS_ACTIVE_HIGH != 0) ? vs_rise_c : vs_fall_c;

   // Index is quasi-static relative to the toggle, so a plain double flop is enough.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         idx_s0_q    <= '0;
         idx_s1_q    <= '0;
         last_idx_q  <= '0;
         frame_valid <= 1'b0;
      end else begin
         idx_s0_q <= wr_done_index;
         idx_s1_q <= idx_s0_q;
         if (done_evt_c) begin
            last_idx_q  <= idx_s1_q;
            frame_valid <= 1'b1;
         end
      end
   end

   // Request FSM; frame starts seen while a request is outstanding are counted as lost.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         timeout_err <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_start_c) begin
                  req_q   <= 1'b1;
                  addr_q  <= frame_valid ? last_idx_q : '0;
                  cnt_q   <= '0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (frame_start_c && overrun_cnt != 8'hFF)
                  overrun_cnt <= overrun_cnt + 8'd1;
               if (rd.read_req_ack) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                  req_q       <= 1'b0;
                  timeout_err <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd.read_req        = req_q;
   assign rd.read_addr_index = addr_q;

`ifdef LCD_READ_REPEAT_STAT_EN
   logic launch_c;
   logic new_frame_q;

   assign launch_c = (state_q == IDLE) && frame_start_c;

   // A done event landing on the launch cycle wins, so that bank still counts as fresh next frame.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         new_frame_q <= 1'b0;
         repeat_cnt  <= '0;
      end else begin
         if (launch_c && !new_frame_q && frame_valid && repeat_cnt != 16'hFFFF)
            repeat_cnt <= repeat_cnt + 16'd1;
         if (done_evt_c)
            new_frame_q <= 1'b1;
         else if (launch_c)
            new_frame_q <= 1'b0;
      end
   end
`else
   assign repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_read_req_gen.sv
// Randomized + directed bench for lcd_read_req_gen against a transaction-level model.
module tb_lcd_read_req_gen;

   localparam int unsigned IW = 2;
   localparam int unsigned TO = 16;

   logic          pclk = 1'b0;
   logic          rst = 1'b1;
   logic          lcd_vsync = 1'b0;
   logic          wr_done_toggle = 1'b0;
   logic [IW-1:0] wr_done_index = '0;
   logic          frame_valid, timeout_err;
   logic [7:0]    overrun_cnt;
   logic [15:0]   repeat_cnt;

   lcd_read_req_gen_if #(.INDEX_W(IW)) rd_if ();

   lcd_read_req_gen #(
      .INDEX_W        (IW),
      .SYNC_STAGES    (2),
      .ACK_TIMEOUT    (TO),
      .VS_ACTIVE_HIGH (1)
   ) dut (
      .rst            (rst),
      .pclk           (pclk),
      .lcd_vsync      (lcd_vsync),
      .wr_done_toggle (wr_done_toggle),
      .wr_done_index  (wr_done_index),
      .rd             (rd_if),
      .frame_valid    (frame_valid),
      .timeout_err    (timeout_err),
      .overrun_cnt    (overrun_cnt),
      .repeat_cnt     (repeat_cnt)
   );

   always #5 pclk = ~pclk;

   int n_total = 0;
   int n_pass  = 0;

   // Transaction-level model state
   bit            m_valid, m_new;
   logic [IW-1:0] m_last, m_idx;
   int            m_rep, m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   function automatic int rep_exp();
`ifdef LCD_READ_REPEAT_STAT_EN
      return m_rep;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_new = 1'b0; m_last = '0; m_idx = '0; m_rep = 0; m_ovr = 0;
   endtask

   task automatic model_done(input logic [IW-1:0] idx);
      m_last = idx; m_valid = 1'b1; m_new = 1'b1;
   endtask

   task automatic model_launch();
      m_idx = m_valid ? m_last : '0;
      if (!m_new && m_valid && m_rep < 65535) m_rep++;
      m_new = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},  32'(rd_if.read_req), 32'd0);
      check({tag, "_idx"},  32'(rd_if.read_addr_index), 32'd0);
      check({tag, "_fv"},   32'(frame_valid), 32'd0);
      check({tag, "_terr"}, 32'(timeout_err), 32'd0);
      check({tag, "_ovr"},  32'(overrun_cnt), 32'd0);
      check({tag, "_rep"},  32'(repeat_cnt), 32'd0);
   endtask

   // One frame: optional done toggle at offset 'off' cycles before vsync (negative = after),
   // then either ack seen 'ack_at' cycles after launch or (ack_at==0) a timeout.
   task automatic do_frame(input bit do_done, input int off, input logic [IW-1:0] idx,
                           input int ack_at, input bit scramble);
      for (int k = 0; k < 8; k++) begin
         if (do_done && k == 4 - off) begin
            wr_done_toggle = ~wr_done_toggle;
            wr_done_index  = idx;
         end
         if (k == 4) lcd_vsync = 1'b1;
         if (k == 6) check("pre_launch_req", 32'(rd_if.read_req), 32'd0);
         if (k == 7) begin
            if (do_done && off > 0) model_done(idx);
            model_launch();
            if (do_done && off == 0) model_done(idx);
            check("launch_req", 32'(rd_if.read_req), 32'd1);
            check("launch_idx", 32'(rd_if.read_addr_index), 32'(m_idx));
            check("launch_fv",  32'(frame_valid), 32'(m_valid));
         end
         tick();
      end
      if (do_done && off < 0) model_done(idx);
      lcd_vsync = 1'b0;
      if (scramble) wr_done_index = ~idx;
      if (ack_at > 0) begin
         tick(ack_at - 2);
         check("hold_req", 32'(rd_if.read_req), 32'd1);
         check("hold_idx", 32'(rd_if.read_addr_index), 32'(m_idx));
         rd_if.read_req_ack = 1'b1;
         tick();
         check("ack_drop_req", 32'(rd_if.read_req), 32'd0);
         check("ack_no_terr",  32'(timeout_err), 32'd0);
         rd_if.read_req_ack = 1'b0;
      end else begin
         tick(TO - 2);
         check("to_hold_req", 32'(rd_if.read_req), 32'd1);
         check("to_pre_terr", 32'(timeout_err), 32'd0);
         tick();
         check("to_drop_req", 32'(rd_if.read_req), 32'd0);
         check("to_terr",     32'(timeout_err), 32'd1);
         tick();
         check("to_terr_end", 32'(timeout_err), 32'd0);
      end
      check("frame_ovr", 32'(overrun_cnt), 32'(m_ovr));
      check("frame_rep", 32'(repeat_cnt), 32'(rep_exp()));
      tick(6);
   endtask

   // vsync pulse train with period 4 and no acks; a start launches only once the
   // previous request has timed out strictly before it.
   task automatic train(input int n);
      int busy_end;
      busy_end = -1000;
      for (int s = 0; s < n; s++) begin
         if (4 * s > busy_end) begin
            model_launch();
            busy_end = 4 * s + int'(TO);
         end else if (m_ovr < 255) begin
            m_ovr++;
         end
         lcd_vsync = 1'b1;
         tick(2);
         lcd_vsync = 1'b0;
         tick(2);
      end
      tick(TO + 8);
      check("train_ovr", 32'(overrun_cnt), 32'(m_ovr));
      check("train_rep", 32'(repeat_cnt), 32'(rep_exp()));
      check("train_idle_req", 32'(rd_if.read_req), 32'd0);
   endtask

   initial begin
      bit            dd;
      int            off, ack_at;
      logic [IW-1:0] ridx;

      rd_if.read_req_ack = 1'b0;
      model_reset();
      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(3);

      // First frame after power-up: bank 0, no valid frame yet
      do_frame(1'b0, 0, '0, 5, 1'b0);

      // Completed write of bank 2, then a frame with wr_done_index scrambled during REQ
      wr_done_toggle = ~wr_done_toggle;
      wr_done_index  = 2'd2;
      model_done(2'd2);
      tick(10);
      check("done_fv", 32'(frame_valid), 32'd1);
      do_frame(1'b0, 0, '0, 8, 1'b1);

      // Timeout then a fresh request on the next vsync
      do_frame(1'b0, 0, '0, 0, 1'b0);
      do_frame(1'b0, 0, '0, 4, 1'b0);

      // Done landing on the launch cycle: old bank now, new bank next frame
      do_frame(1'b1, 0, 2'd1, 6, 1'b0);
      do_frame(1'b0, 0, '0, 3, 1'b0);

      // Lost frame starts, then saturation
      train(4);
      train(400);

      for (int i = 0; i < 30; i++) begin
         dd     = 1'($urandom_range(0, 1));
         off    = int'($urandom_range(0, 6)) - 3;
         ridx   = IW'($urandom);
         ack_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 16));
         do_frame(dd, off, ridx, ack_at, 1'b0);
      end

      // Asynchronous reset in the middle of a request
      lcd_vsync = 1'b1;
      tick(3);
      check("pre_rst_req", 32'(rd_if.read_req), 32'd1);
      #2;
      rst            = 1'b1;
      lcd_vsync      = 1'b0;
      wr_done_toggle = 1'b0;
      wr_done_index  = '0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      tick(2);
      rst = 1'b0;
      tick(3);
      do_frame(1'b0, 0, '0, 4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
